// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the digit-serial multiplier.
// Holds the FSM state encoding and parameter sanity checks.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic bit digits_ok(input int w, input int d);
        return (d >= 1) && (d <= w) && ((w % d) == 0);
    endfunction

endpackage

// File: rtl/dsp_digit_mult.sv
// Combinational W x D unsigned partial-product slice.
// Sized so it maps onto a single DSP block.
(* use_dsp48 = "yes" *)
module dsp_digit_mult #(
    parameter int W = 16,
    parameter int D = 4
) (
    input  logic [W-1:0]   i_a,
    input  logic [D-1:0]   i_digit,
    output logic [W+D-1:0] o_prod
);

    assign o_prod = (W+D)'(i_a) * (W+D)'(i_digit);

endmodule

// File: rtl/digit_serial_mult.sv
// Digit-serial unsigned multiplier, one D-bit digit of B per cycle.
// Define MULT_MAC_EN to add in_acc (accumulate onto last product).
module digit_serial_mult
    import mult_pkg::*;
#(
    parameter int W = 16,
    parameter int D = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
`ifdef MULT_MAC_EN
    input  logic           in_acc,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_prod,
    output logic           busy
);

    localparam int NUM_DIGITS = W / D;
    localparam int CW = cnt_width(NUM_DIGITS);
    localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);

    if (!digits_ok(W, D)) begin : g_bad_cfg
        $error("digit_serial_mult: W must be a multiple of D");
    end

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [CW-1:0]  r_cnt;
    logic [2*W-1:0] r_acc;
    logic [2*W-1:0] r_prod;
    logic [W+D-1:0] w_partial;
    logic [2*W-1:0] w_acc_nxt;
    logic [2*W-1:0] w_addend;
    logic           w_accept;
    logic           w_last;

    dsp_digit_mult #(
        .W(W),
        .D(D)
    ) u_dsp (
        .i_a    (r_a),
        .i_digit(r_b[D-1:0]),
        .o_prod (w_partial)
    );

    // Partial lands in the top W+D bits; earlier terms slide right by D.
    assign w_acc_nxt = (r_acc >> D)
                     + ((2*W)'(w_partial) << (W - D));

    assign w_accept  = (r_state == IDLE) && in_valid;
    assign w_last    = (r_state == BUSY) && (r_cnt == LAST);
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_prod  = r_prod;

`ifdef MULT_MAC_EN
    logic r_mac;
    // Preloaded term shifted out of the window, so it is added at the end.
    assign w_addend = r_mac ? r_prod : '0;
`else
    assign w_addend = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (in_valid) w_state_nxt = BUSY;
            BUSY: if (w_last) w_state_nxt = DONE;
            DONE: if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_prod <= '0;
`ifdef MULT_MAC_EN
            r_mac  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a   <= in_a;
            r_b   <= in_b;
            r_cnt <= '0;
            r_acc <= '0;
`ifdef MULT_MAC_EN
            r_mac <= in_acc;
`endif
        end else if (r_state == BUSY) begin
            r_acc <= w_acc_nxt;
            r_b   <= r_b >> D;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_prod <= w_acc_nxt + w_addend;
            end
        end
    end

endmodule

// File: tb/tb_digit_serial_mult.sv
// Directed and randomized checks for digit_serial_mult.
// Two instances: W=16/D=4 and W=12/D=6.
module tb_digit_serial_mult;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // 16-bit instance
    logic        v16 = 1'b0;
    logic        rdy16;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        ov16;
    logic        or16 = 1'b0;
    logic [31:0] p16;
    logic        busy16;
`ifdef MULT_MAC_EN
    logic        acc16 = 1'b0;
`endif

    // 12-bit instance
    logic        v12 = 1'b0;
    logic        rdy12;
    logic [11:0] a12 = '0;
    logic [11:0] b12 = '0;
    logic        ov12;
    logic        or12 = 1'b0;
    logic [23:0] p12;
    logic        busy12;
`ifdef MULT_MAC_EN
    logic        acc12 = 1'b0;
`endif

    digit_serial_mult #(.W(16), .D(4)) u16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (v16),
        .in_ready (rdy16),
        .in_a     (a16),
        .in_b     (b16),
`ifdef MULT_MAC_EN
        .in_acc   (acc16),
`endif
        .out_valid(ov16),
        .out_ready(or16),
        .out_prod (p16),
        .busy     (busy16)
    );

    digit_serial_mult #(.W(12), .D(6)) u12 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (v12),
        .in_ready (rdy12),
        .in_a     (a12),
        .in_b     (b12),
`ifdef MULT_MAC_EN
        .in_acc   (acc12),
`endif
        .out_valid(ov12),
        .out_ready(or12),
        .out_prod (p12),
        .busy     (busy12)
    );

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    // Present one operand pair; return at the negedge after acceptance.
    task automatic issue16(input logic [15:0] a,
                           input logic [15:0] b);
        @(negedge clk);
        a16 = a;
        b16 = b;
        v16 = 1'b1;
        check("rdy_idle", 64'(rdy16), 64'd1);
        @(negedge clk);
        v16 = 1'b0;
        a16 = 16'($urandom);
        b16 = 16'($urandom);
        check("busy_start", 64'(busy16), 64'd1);
        check("rdy_busy", 64'(rdy16), 64'd0);
    endtask

    // Product must appear exactly 4 edges after acceptance.
    task automatic expect16(input logic [31:0] exp);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lat_low", 64'(ov16), 64'd0);
            check("lat_busy", 64'(busy16), 64'd1);
            check("lat_rdy", 64'(rdy16), 64'd0);
        end
        @(negedge clk);
        check("lat_valid", 64'(ov16), 64'd1);
        check("lat_busy_done", 64'(busy16), 64'd1);
        check("prod16", 64'(p16), 64'(exp));
    endtask

    task automatic drain16;
        or16 = 1'b1;
        @(negedge clk);
        or16 = 1'b0;
        check("drain_ov", 64'(ov16), 64'd0);
        check("drain_rdy", 64'(rdy16), 64'd1);
        check("drain_busy", 64'(busy16), 64'd0);
    endtask

    initial begin
        logic [23:0] q[$];
        logic [23:0] e;
        logic [23:0] ref_v;
        int sent;
        int got;
        int cyc;
        bit took;

        // Reset values
        #2;
        check("rst_rdy16", 64'(rdy16), 64'd1);
        check("rst_ov16", 64'(ov16), 64'd0);
        check("rst_p16", 64'(p16), 64'd0);
        check("rst_busy16", 64'(busy16), 64'd0);
        check("rst_rdy12", 64'(rdy12), 64'd1);
        check("rst_p12", 64'(p12), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Max operands
        issue16(16'hFFFF, 16'hFFFF);
        expect16(32'hFFFE0001);
        drain16();

        // Zero multiplier, full latency
        issue16(16'h1234, 16'h0000);
        expect16(32'h0);
        drain16();

        // Backpressure, new request in DONE must be refused
        issue16(16'd3, 16'd5);
        expect16(32'd15);
        v16 = 1'b1;
        a16 = 16'd9;
        b16 = 16'd9;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_ov", 64'(ov16), 64'd1);
            check("bp_prod", 64'(p16), 64'd15);
            check("bp_rdy", 64'(rdy16), 64'd0);
        end
        v16 = 1'b0;
        drain16();

        // Reset after two digits
        issue16(16'hABCD, 16'h1234);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ov", 64'(ov16), 64'd0);
        check("mid_rst_p", 64'(p16), 64'd0);
        check("mid_rst_rdy", 64'(rdy16), 64'd1);
        check("mid_rst_busy", 64'(busy16), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue16(16'd7, 16'd9);
        expect16(32'd63);
        drain16();

        // Random stream on the 12/6 instance
        sent = 0;
        got = 0;
        cyc = 0;
        took = 1'b0;
        while (got < 1000 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (took) v12 = 1'b0;
            if (!v12 && sent < 1000 && $urandom_range(3) != 0) begin
                v12 = 1'b1;
                a12 = 12'($urandom);
                b12 = 12'($urandom);
            end
            or12 = ($urandom_range(2) != 0);
            took = v12 && rdy12;
            if (took) begin
                e = {12'd0, a12} * {12'd0, b12};
                q.push_back(e);
                sent++;
            end
            if (ov12 && or12) begin
                if (q.size() == 0) begin
                    check("rand_extra", 64'(p12), 64'hDEAD);
                end else begin
                    ref_v = q.pop_front();
                    check("rand_prod", 64'(p12), 64'(ref_v));
                end
                got++;
            end
        end
        v12 = 1'b0;
        or12 = 1'b0;
        check("rand_count", 64'(got), 64'd1000);
        check("rand_left", 64'(q.size()), 64'd0);

`ifdef MULT_MAC_EN
        acc16 = 1'b0;
        issue16(16'd2, 16'd3);
        expect16(32'd6);
        drain16();
        acc16 = 1'b1;
        issue16(16'd4, 16'd5);
        expect16(32'd26);
        drain16();
        issue16(16'hFFFF, 16'hFFFF);
        expect16(32'hFFFE001B);
        drain16();
        acc16 = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
